// File: rtl/sprite_move_ctrl.sv
// sprite_move_ctrl: moves a SPR_W x SPR_H sprite around the VGA plotting
// surface. Each accepted tick erases the box at the old position, steps the
// position by STEP (clamped to the screen), then redraws the box, one pixel
// per cycle, straight onto the adapter's plot/x/y/colour inputs.
module sprite_move_ctrl #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119,
  parameter int SPR_W  = 4,
  parameter int SPR_H  = 4,
  parameter int STEP   = 1,
  parameter int X_INIT = 5,
  parameter int Y_INIT = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic           stop,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           plot,
  output logic           erase,
  output logic           busy,
  output logic [3:0]     dir_state,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y
);

  // Largest legal top-left corner so the whole box stays on screen.
  localparam int X_LIM = X_MAX - SPR_W + 1;
  localparam int Y_LIM = Y_MAX - SPR_H + 1;
  localparam int CX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  localparam logic [3:0] DIR_REST  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;

  state_t          state_q, state_d;
  logic            init_pend_q, init_pend_d;
  logic [X_W-1:0]  pos_x_q, pos_x_d;
  logic [Y_W-1:0]  pos_y_q, pos_y_d;
  logic [3:0]      dir_q, dir_d;
  logic [3:0]      mv_dir_q, mv_dir_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  logic [3:0]      dir_in;
  logic            req_load;
  logic [3:0]      sel_dir;
  logic [X_W-1:0]  tgt_x;
  logic [Y_W-1:0]  tgt_y;
  logic            tgt_same;
  logic            tgt_on_bound;
  logic            last_col;
  logic            last_row;

  // Direction request decode: stop wins, then up > down > left > right.
  always_comb begin
    dir_in   = dir_q;
    req_load = 1'b1;
    if (stop)       dir_in = DIR_REST;
    else if (up)    dir_in = DIR_UP;
    else if (down)  dir_in = DIR_DOWN;
    else if (left)  dir_in = DIR_LEFT;
    else if (right) dir_in = DIR_RIGHT;
    else            req_load = 1'b0;
  end

  // Clamped target for the live direction (IDLE) or the latched one (MOVE);
  // every clamp compares before it subtracts so nothing wraps.
  always_comb begin
    sel_dir      = (state_q == S_IDLE) ? dir_q : mv_dir_q;
    tgt_x        = pos_x_q;
    tgt_y        = pos_y_q;
    tgt_on_bound = 1'b0;
    case (sel_dir)
      DIR_UP: begin
        tgt_y        = (int'(pos_y_q) >= STEP) ? pos_y_q - Y_W'(STEP) : '0;
        tgt_on_bound = (tgt_y == '0);
      end
      DIR_DOWN: begin
        tgt_y        = (int'(pos_y_q) + STEP >= Y_LIM) ? Y_W'(Y_LIM) : pos_y_q + Y_W'(STEP);
        tgt_on_bound = (tgt_y == Y_W'(Y_LIM));
      end
      DIR_LEFT: begin
        tgt_x        = (int'(pos_x_q) >= STEP) ? pos_x_q - X_W'(STEP) : '0;
        tgt_on_bound = (tgt_x == '0);
      end
      DIR_RIGHT: begin
        tgt_x        = (int'(pos_x_q) + STEP >= X_LIM) ? X_W'(X_LIM) : pos_x_q + X_W'(STEP);
        tgt_on_bound = (tgt_x == X_W'(X_LIM));
      end
      default: ;
    endcase
    tgt_same = (tgt_x == pos_x_q) && (tgt_y == pos_y_q);
  end

  assign last_col = (cx_q == CX_W'(SPR_W - 1));
  assign last_row = (cy_q == CY_W'(SPR_H - 1));

  // Sweep sequencer: next state, position, scan counters and direction.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d     = state_q;
    init_pend_d = init_pend_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    mv_dir_d    = mv_dir_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    dir_d       = dir_in;

    case (state_q)
      S_IDLE: begin
        cx_d = '0;
        cy_d = '0;
        if (init_pend_q) begin
          init_pend_d = 1'b0;
          state_d     = S_DRAW;
        end else if (tick && dir_q != DIR_REST) begin
          if (tgt_same) begin
            // Already against the edge: nothing to sweep, drop back to rest.
            dir_d = DIR_REST;
          end else begin
            mv_dir_d = dir_q;
            state_d  = S_ERASE;
          end
        end
      end
      S_ERASE, S_DRAW: begin
        if (last_col) begin
          cx_d = '0;
          if (last_row) begin
            cy_d    = '0;
            state_d = (state_q == S_ERASE) ? S_MOVE : S_IDLE;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_MOVE: begin
        pos_x_d = tgt_x;
        pos_y_d = tgt_y;
        // Reaching the edge parks the sprite unless a request arrives now.
        if (tgt_on_bound && !req_load) dir_d = DIR_REST;
        state_d = S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q     <= S_IDLE;
      init_pend_q <= 1'b1;
      pos_x_q     <= X_W'(X_INIT);
      pos_y_q     <= Y_W'(Y_INIT);
      dir_q       <= DIR_REST;
      mv_dir_q    <= DIR_REST;
      cx_q        <= '0;
      cy_q        <= '0;
    end else begin
      state_q     <= state_d;
      init_pend_q <= init_pend_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      mv_dir_q    <= mv_dir_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
    end
  end

  // Pixel stream: scan offset added to the current corner while plotting.
  always_comb begin
    plot  = (state_q == S_ERASE) || (state_q == S_DRAW);
    erase = (state_q == S_ERASE);
    x_out = plot ? pos_x_q + X_W'(cx_q) : pos_x_q;
    y_out = plot ? pos_y_q + Y_W'(cy_q) : pos_y_q;
  end

  assign busy      = (state_q != S_IDLE) || init_pend_q;
  assign dir_state = dir_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// tb_sprite_move_ctrl: two controllers share one stimulus stream: index 0
// uses default parameters, index 1 uses STEP=3 starting at x=154 to hit the
// right-edge clamp. A sweep-indexed model predicts every output each cycle;
// literal checks in the stimulus pin the model to hand-worked values.
module tb_sprite_move_ctrl;

  localparam int N     = 16;   // 4x4 sprite
  localparam int SW    = 4;
  localparam int X_LIM = 156;
  localparam int Y_LIM = 116;

  logic clock = 1'b0;
  logic reset_n, tick, up, down, left, right, stop;

  logic [7:0] xo   [2];
  logic [6:0] yo   [2];
  logic       po   [2];
  logic       eo   [2];
  logic       bo   [2];
  logic [3:0] do_s [2];
  logic [7:0] pxo  [2];
  logic [6:0] pyo  [2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  sprite_move_ctrl u_dut0 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .up(up), .down(down),
    .left(left), .right(right), .stop(stop),
    .x_out(xo[0]), .y_out(yo[0]), .plot(po[0]), .erase(eo[0]), .busy(bo[0]),
    .dir_state(do_s[0]), .pos_x(pxo[0]), .pos_y(pyo[0])
  );

  sprite_move_ctrl #(
    .X_W(8), .Y_W(7), .X_MAX(159), .Y_MAX(119), .SPR_W(4), .SPR_H(4),
    .STEP(3), .X_INIT(154), .Y_INIT(5)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .up(up), .down(down),
    .left(left), .right(right), .stop(stop),
    .x_out(xo[1]), .y_out(yo[1]), .plot(po[1]), .erase(eo[1]), .busy(bo[1]),
    .dir_state(do_s[1]), .pos_x(pxo[1]), .pos_y(pyo[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mk = position in the current sweep: -1 idle, 0..N-1 erase pixels,
  // N the move cycle, N+1..2N draw pixels.
  int         mx [2], my [2], mk [2], ox [2], oy [2], tx [2], ty [2];
  logic [3:0] mdir [2], mvd [2];
  bit         minit [2];
  bit         model_ok = 1'b0;

  function automatic int p_step(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int p_xinit(input int i);
    return (i == 0) ? 5 : 154;
  endfunction

  function automatic logic [3:0] dir_rule(input logic [3:0] cur);
    if (stop)  return 4'b0000;
    if (up)    return 4'b1000;
    if (down)  return 4'b0100;
    if (left)  return 4'b0010;
    if (right) return 4'b0001;
    return cur;
  endfunction

  always @(posedge clock) begin : model_step
    logic [3:0] dn;
    int nx, ny, s;
    bit edge_hit;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mx[i] = p_xinit(i); my[i] = 5; mdir[i] = 4'b0000;
        minit[i] = 1'b1; mk[i] = -1;
      end else begin
        dn = dir_rule(mdir[i]);
        s  = p_step(i);
        if (mk[i] >= 0) begin
          if (mk[i] == N) begin
            mx[i] = tx[i]; my[i] = ty[i];
            edge_hit = (mvd[i] == 4'b1000 && my[i] == 0) ||
                       (mvd[i] == 4'b0100 && my[i] == Y_LIM) ||
                       (mvd[i] == 4'b0010 && mx[i] == 0) ||
                       (mvd[i] == 4'b0001 && mx[i] == X_LIM);
            if (edge_hit && !(stop || up || down || left || right)) dn = 4'b0000;
          end
          mk[i]++;
          if (mk[i] == 2 * N + 1) mk[i] = -1;
        end else if (minit[i]) begin
          minit[i] = 1'b0; tx[i] = mx[i]; ty[i] = my[i]; mk[i] = N + 1;
        end else if (tick && mdir[i] != 4'b0000) begin
          nx = mx[i]; ny = my[i];
          case (mdir[i])
            4'b1000: ny = (my[i] >= s) ? my[i] - s : 0;
            4'b0100: ny = (my[i] + s > Y_LIM) ? Y_LIM : my[i] + s;
            4'b0010: nx = (mx[i] >= s) ? mx[i] - s : 0;
            default: nx = (mx[i] + s > X_LIM) ? X_LIM : mx[i] + s;
          endcase
          if (nx == mx[i] && ny == my[i]) begin
            dn = 4'b0000;
          end else begin
            ox[i] = mx[i]; oy[i] = my[i]; tx[i] = nx; ty[i] = ny;
            mvd[i] = mdir[i]; mk[i] = 0;
          end
        end
        mdir[i] = dn;
      end
    end
    if (!reset_n) model_ok = 1'b1;
  end

  // Compare every DUT output against the model, away from the active edge.
  always @(negedge clock) begin
    int ep, ee, ex, ey, j;
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        ee = 0;
        if (mk[i] >= 0 && mk[i] < N) begin
          ep = 1; ee = 1; ex = ox[i] + mk[i] % SW; ey = oy[i] + mk[i] / SW;
        end else if (mk[i] > N) begin
          j = mk[i] - N - 1;
          ep = 1; ex = tx[i] + j % SW; ey = ty[i] + j / SW;
        end else begin
          ep = 0; ex = mx[i]; ey = my[i];
        end
        check($sformatf("dut%0d plot", i), int'(po[i]), ep);
        check($sformatf("dut%0d busy", i), int'(bo[i]), int'(mk[i] >= 0 || minit[i]));
        check($sformatf("dut%0d dir_state", i), int'(do_s[i]), int'(mdir[i]));
        check($sformatf("dut%0d pos_x", i), int'(pxo[i]), mx[i]);
        check($sformatf("dut%0d pos_y", i), int'(pyo[i]), my[i]);
        check($sformatf("dut%0d x_out", i), int'(xo[i]), ex);
        check($sformatf("dut%0d y_out", i), int'(yo[i]), ey);
        if (ep == 1) check($sformatf("dut%0d erase", i), int'(eo[i]), ee);
      end
    end
  end

  task automatic nedge(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0;
    left = 1'b0; right = 1'b0; stop = 1'b0;
    nedge(3);
    // Reset state.
    check("lit reset busy", int'(bo[0]), 1);
    check("lit reset plot", int'(po[0]), 0);
    check("lit reset dir", int'(do_s[0]), 0);
    check("lit reset pos_x", int'(pxo[0]), 5);
    check("lit reset pos_y", int'(pyo[0]), 5);
    reset_n = 1'b1;
    // Initial draw at (5..8, 5..8), row-major.
    nedge(1);
    check("lit init px0 x", int'(xo[0]), 5);
    check("lit init px0 y", int'(yo[0]), 5);
    check("lit init px0 erase", int'(eo[0]), 0);
    nedge(1);
    check("lit init px1 x", int'(xo[0]), 6);
    check("lit init px1 y", int'(yo[0]), 5);
    nedge(14);
    check("lit init px15 x", int'(xo[0]), 8);
    check("lit init px15 y", int'(yo[0]), 8);
    nedge(1);
    check("lit init done busy", int'(bo[0]), 0);
    check("lit init done dir", int'(do_s[0]), 0);
    // Right, then one tick.
    right = 1'b1;
    nedge(1);
    check("lit right dir0", int'(do_s[0]), 1);
    check("lit right dir1", int'(do_s[1]), 1);
    tick = 1'b1;
    nedge(1);
    tick = 1'b0; right = 1'b0;
    check("lit erase px0 x", int'(xo[0]), 5);
    check("lit erase px0 erase", int'(eo[0]), 1);
    nedge(16);
    check("lit move plot", int'(po[0]), 0);
    nedge(1);
    check("lit draw px0 x", int'(xo[0]), 6);
    check("lit draw px0 erase", int'(eo[0]), 0);
    nedge(15);
    check("lit draw px15 x", int'(xo[0]), 9);
    check("lit draw px15 busy", int'(bo[0]), 1);
    nedge(1);
    check("lit idle at 34 busy", int'(bo[0]), 0);
    check("lit moved pos_x0", int'(pxo[0]), 6);
    check("lit clamp pos_x1", int'(pxo[1]), 156);
    check("lit clamp dir1", int'(do_s[1]), 0);
    // Tick again: dut1 is parked, dut0 still heading right.
    tick = 1'b1;
    nedge(1);
    tick = 1'b0;
    check("lit parked busy1", int'(bo[1]), 0);
    check("lit parked plot1", int'(po[1]), 0);
    check("lit second sweep x0", int'(xo[0]), 6);
    // Stop mid-erase.
    nedge(7);
    stop = 1'b1;
    nedge(1);
    stop = 1'b0;
    check("lit stop dir0", int'(do_s[0]), 0);
    check("lit stop still plotting", int'(po[0]), 1);
    // Tick during draw must be dropped.
    nedge(14);
    tick = 1'b1;
    nedge(1);
    tick = 1'b0;
    nedge(4);
    check("lit draw px10 x", int'(xo[0]), 9);
    check("lit draw px10 y", int'(yo[0]), 7);
    nedge(6);
    check("lit sweep2 busy", int'(bo[0]), 0);
    check("lit sweep2 pos_x", int'(pxo[0]), 7);
    nedge(3);
    check("lit dropped tick busy", int'(bo[0]), 0);
    // Walk up to the top edge; the last attempt has nowhere to go.
    for (int it = 0; it < 6; it++) begin
      up = 1'b1;
      nedge(1);
      up = 1'b0; tick = 1'b1;
      nedge(1);
      tick = 1'b0;
      if (it == 5) begin
        check("lit top dir0", int'(do_s[0]), 0);
        check("lit top busy0", int'(bo[0]), 0);
        check("lit top plot0", int'(po[0]), 0);
      end
      nedge(36);
    end
    check("lit top pos_y0", int'(pyo[0]), 0);
    check("lit top pos_y1", int'(pyo[1]), 0);
    // Reset during erase pixel 7 of a move from (7,0).
    right = 1'b1;
    nedge(1);
    right = 1'b0; tick = 1'b1;
    nedge(1);
    tick = 1'b0;
    nedge(7);
    check("lit erase px7 x", int'(xo[0]), 10);
    check("lit erase px7 y", int'(yo[0]), 1);
    reset_n = 1'b0;
    nedge(1);
    check("lit abort plot", int'(po[0]), 0);
    check("lit abort pos_x", int'(pxo[0]), 5);
    check("lit abort pos_y", int'(pyo[0]), 5);
    check("lit abort busy", int'(bo[0]), 1);
    reset_n = 1'b1;
    nedge(1);
    check("lit redraw px0 plot", int'(po[0]), 1);
    check("lit redraw px0 erase", int'(eo[0]), 0);
    nedge(17);
    check("lit redraw done busy", int'(bo[0]), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
